// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared rv32i constants and address helpers for the fetch stage
package rv32i_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry synchronous FIFO of {pc, instr} pairs feeding decode
//   clk, reset        clock and synchronous active-high reset
//   push_i            write {push_pc_i, push_instr_i} at the tail
//   pop_i             retire the head entry
//   flush_i           drop every entry (wins over push/pop)
//   head_pc_o         pc of the head entry (meaningful when count_o != 0)
//   head_instr_o      instruction of the head entry
//   count_o           number of valid entries
module fetch_buffer #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 8,
   parameter int XLEN   = rv32i_pkg::XLEN,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] push_pc_i,
   input  logic [XLEN-1:0]   push_instr_i,
   output logic [ADDR_W-1:0] head_pc_o,
   output logic [XLEN-1:0]   head_instr_o,
   output logic [CW-1:0]     count_o
);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   logic [ADDR_W-1:0] pc_mem_q [DEPTH];
   logic [XLEN-1:0]   instr_mem_q [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   always_comb begin
      head_d  = flush_i ? '0 : pop_i ? (head_q == LAST ? '0 : head_q + 1'b1) : head_q;
      tail_d  = flush_i ? '0 : push_i ? (tail_q == LAST ? '0 : tail_q + 1'b1) : tail_q;
      count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   // Storage needs no reset: it is only observed through count_o != 0.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i && !reset) begin
         pc_mem_q[tail_q]    <= push_pc_i;
         instr_mem_q[tail_q] <= push_instr_i;
      end
   end
   assign head_pc_o    = pc_mem_q[head_q];
   assign head_instr_o = instr_mem_q[head_q];
   assign count_o      = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: rv32i instruction-fetch stage with PC, in-flight tracking and a decode buffer
//   clk, reset        clock and synchronous active-high reset
//   imem_req          fetch issued this cycle
//   imem_addr         word-aligned byte address of this cycle's fetch
//   imem_rdata        instruction returned for last cycle's request
//   redirect          taken branch/jump: flush and restart at redirect_pc
//   redirect_pc       new fetch target (low two bits ignored)
//   if_valid          if_instr/if_pc hold a valid instruction
//   if_instr          head instruction, NOP when not valid
//   if_pc             head pc, 0 when not valid
//   id_ready          decode accepts the head this cycle
module fetch_unit #(
   parameter int XLEN   = rv32i_pkg::XLEN,
   parameter int ADDR_W = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = rv32i_pkg::RESET_PC_DEFAULT[ADDR_W-1:0],
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [XLEN-1:0]   imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              if_valid,
   output logic [XLEN-1:0]   if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              id_ready
);
   import rv32i_pkg::*;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;
   logic [ADDR_W-1:0] pc_q, pc_d, fly_pc_q, fly_pc_d;
   logic              inflight_q, inflight_d;
   logic              pop, push, req;
   logic [CW-1:0]     count;
   logic [OW-1:0]     occupancy;
   logic [ADDR_W-1:0] head_pc;
   logic [XLEN-1:0]   head_instr;
   assign if_valid  = count != '0;
   assign if_pc     = if_valid ? head_pc : '0;
   assign if_instr  = if_valid ? head_instr : NOP_INSTR;
   assign pop       = if_valid & id_ready;
   // A returning word is kept only if no redirect has flushed it.
   assign push      = inflight_q & ~redirect;
   // Entries that will be held next cycle; a new request needs a free slot for its data.
   assign occupancy = {1'b0, count} + OW'(inflight_q) - OW'(pop);
   assign req       = ~reset & ~redirect & (occupancy < OW'(DEPTH));
   assign imem_req  = req;
   assign imem_addr = pc_q;
   always_comb begin
      pc_d       = redirect ? ADDR_W'(word_align(XLEN'(redirect_pc))) : req ? pc_q + ADDR_W'(4) : pc_q;
      inflight_d = req;
      fly_pc_d   = req ? pc_q : fly_pc_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         fly_pc_q   <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         fly_pc_q   <= fly_pc_d;
      end
   end
   fetch_buffer #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .XLEN  (XLEN)
   ) u_buf (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (redirect),
      .push_pc_i   (fly_pc_q),
      .push_instr_i(imem_rdata),
      .head_pc_o   (head_pc),
      .head_instr_o(head_instr),
      .count_o     (count)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
   localparam int DEPTH = 2;
   logic        clk = 1'b0;
   logic        reset, redirect, id_ready;
   logic [7:0]  redirect_pc;
   logic        imem_req, if_valid;
   logic [7:0]  imem_addr, if_pc;
   logic [31:0] imem_rdata, if_instr;
   logic [31:0] mem [64];
   int          checks = 0;
   int          failures = 0;
   int unsigned q[$];
   bit          infl = 1'b0;
   int unsigned ipc = 0;
   int unsigned npc = 0;
   bit          exp_pop, exp_req;

   fetch_unit #(.XLEN(32), .ADDR_W(8), .RESET_PC(8'h00), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .id_ready   (id_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) imem_rdata <= mem[imem_addr[7:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Apply inputs, then compare every output with the model mid-cycle.
   task automatic drive(input bit r, input bit rd, input logic [7:0] rp, input bit rdy);
      bit v;
      int occ;
      reset = r;
      redirect = rd;
      redirect_pc = rp;
      id_ready = rdy;
      @(negedge clk);
      v = q.size() != 0;
      exp_pop = v && rdy;
      occ = q.size() + int'(infl) - int'(exp_pop);
      exp_req = !r && !rd && (occ < DEPTH);
      chk("if_valid", {31'd0, if_valid}, {31'd0, v});
      chk("if_pc", {24'd0, if_pc}, v ? q[0] : 32'd0);
      chk("if_instr", if_instr, v ? mem[q[0] >> 2] : 32'h13);
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      chk("imem_addr", {24'd0, imem_addr}, npc);
   endtask

   // Advance the model across the clock edge.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         q.delete();
         infl = 1'b0;
         npc = 0;
      end else begin
         if (exp_pop) void'(q.pop_front());
         if (redirect) begin
            q.delete();
            infl = 1'b0;
            npc = redirect_pc & 8'hFC;
         end else begin
            if (infl) q.push_back(ipc);
            infl = exp_req;
            if (exp_req) begin
               ipc = npc;
               npc = (npc + 4) % 256;
            end
         end
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      reset = 1'b1;
      redirect = 1'b0;
      redirect_pc = '0;
      id_ready = 1'b0;
      @(posedge clk);
      #1;
      drive(1, 0, 0, 0);
      chk("rst_instr", if_instr, 32'h13);
      tick();
      // Start-up stream.
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1);
         chk("start_addr", {24'd0, imem_addr}, 4 * i);
         if (i == 2) chk("start_pc", {24'd0, if_pc}, 0);
         if (i == 2) chk("start_instr", if_instr, mem[0]);
         tick();
      end
      // Stall while pc 4 is at the head.
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0);
         chk("stall_pc", {24'd0, if_pc}, 32'h4);
         chk("stall_instr", if_instr, mem[1]);
         if (i >= 1) chk("stall_req", {31'd0, imem_req}, 0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1);
         chk("release_pc", {24'd0, if_pc}, 4 + 4 * i);
         tick();
      end
      drive(0, 0, 0, 1);
      tick();
      // Redirect with a word in flight and a non-empty buffer.
      drive(0, 1, 8'h41, 1);
      chk("redir_busy", {31'd0, if_valid}, 1);
      tick();
      drive(0, 0, 0, 1);
      chk("redir_flush", {31'd0, if_valid}, 0);
      chk("redir_addr", {24'd0, imem_addr}, 32'h40);
      tick();
      drive(0, 0, 0, 1);
      chk("redir_gap", {31'd0, if_valid}, 0);
      tick();
      drive(0, 0, 0, 1);
      chk("redir_pc", {24'd0, if_pc}, 32'h40);
      tick();
      // Address wrap.
      drive(0, 1, 8'hF8, 1);
      tick();
      for (int i = 0; i < 6; i++) begin
         logic [7:0] a;
         drive(0, 0, 0, 1);
         a = 8'hF8 + 8'(4 * i);
         if (i < 4) chk("wrap_addr", {24'd0, imem_addr}, {24'd0, a});
         a = 8'hF8 + 8'(4 * (i - 2));
         if (i >= 2) chk("wrap_pc", {24'd0, if_pc}, {24'd0, a});
         tick();
      end
      // Reset during a full stall.
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0);
         tick();
      end
      drive(1, 0, 0, 0);
      chk("full_before_rst", {31'd0, if_valid}, 1);
      tick();
      drive(1, 0, 0, 0);
      chk("rst_valid", {31'd0, if_valid}, 0);
      chk("rst_nop", if_instr, 32'h13);
      chk("rst_req", {31'd0, imem_req}, 0);
      tick();
      drive(0, 0, 0, 1);
      chk("rst_restart", {24'd0, imem_addr}, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1);
         tick();
      end
      // Reset beats a simultaneous redirect.
      drive(1, 1, 8'h80, 1);
      tick();
      drive(0, 0, 0, 1);
      chk("rst_over_redir", {24'd0, imem_addr}, 0);
      tick();
      // Random traffic.
      for (int i = 0; i < 2500; i++) begin
         drive($urandom_range(99) == 0, $urandom_range(19) == 0, 8'($urandom), $urandom_range(9) < 7);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
